// File: rtl/param_counter_pkg.sv
// param_counter_pkg: shared mode codes and one-shot state encoding for param_updown_counter
package param_counter_pkg;
  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides enabled cycles, tick every prescale+1 cycles; clr restarts the divider (clk, rst, en, clr, prescale -> tick)
module tick_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] div;
  assign tick = en && !clr && div == prescale;
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= '0;
    else if (en) div <= (clr || div == prescale) ? '0 : div + 1'b1;
endmodule

// File: rtl/param_updown_counter.sv
// param_updown_counter: prescaled up/down counter with wrap/saturate/one-shot/hold modes, load, tc pulse, busy/done (clk, rst, en, mode, up_dn, prescale, max_val, load, load_val, start -> count, tc, busy, done)
module param_updown_counter
  import param_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  up_dn,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [WIDTH-1:0]      max_val,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);
  state_e state, state_n;
  logic [WIDTH-1:0] count_n, limit, step_val, wrap_val;
  logic tc_n, tick, at_lim, start_ok;
  assign limit    = up_dn ? max_val : '0;
  // counting up past a lowered max_val is treated as already at the limit
  assign at_lim   = up_dn ? count >= max_val : count == '0;
  assign step_val = up_dn ? count + 1'b1 : count - 1'b1;
  assign wrap_val = up_dn ? '0 : max_val;
  assign start_ok = mode == MODE_ONESHOT && start && state != ST_RUN && !load;
  assign busy     = state == ST_RUN;
  assign done     = state == ST_DONE;
  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk(clk), .rst(rst), .en(en), .clr(load || start_ok), .prescale(prescale), .tick(tick)
  );
  always_comb begin
    count_n = count;
    tc_n    = 1'b0;
    state_n = mode == MODE_ONESHOT ? state : ST_IDLE;
    if (load) count_n = load_val;
    else if (start_ok) begin
      count_n = wrap_val;
      state_n = ST_RUN;
    end else if (mode == MODE_HOLD) tc_n = tc;
    else if (tick && mode != MODE_ONESHOT) begin
      count_n = at_lim ? (mode == MODE_WRAP ? wrap_val : count) : step_val;
      tc_n    = !at_lim && step_val == limit;
    end else if (tick && state == ST_RUN) begin
      count_n = at_lim ? count : step_val;
      tc_n    = !at_lim && step_val == limit;
      state_n = (at_lim || step_val == limit) ? ST_DONE : ST_RUN;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      state <= ST_IDLE;
    end else if (en) begin
      count <= count_n;
      tc    <= tc_n;
      state <= state_n;
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed self-checking bench for param_updown_counter
module tb_param_updown_counter;
  logic clk = 0, rst = 0, en = 0, up_dn = 1, load = 0, start = 0;
  logic [1:0] mode = 2'b00;
  logic [3:0] prescale = 0;
  logic [7:0] max_val = 0, load_val = 0, count;
  logic tc, busy, done;
  int vec = 0, errs = 0;
  param_updown_counter dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .up_dn(up_dn), .prescale(prescale),
    .max_val(max_val), .load(load), .load_val(load_val), .start(start),
    .count(count), .tc(tc), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2 rst = 1;
    #1;
    vec++;
    if ({count, tc, busy, done} !== 11'd0) begin
      errs++;
      $display("FAIL reset_init count=%0d tc=%0b busy=%0b done=%0b required 0/0/0/0", count, tc, busy, done);
    end
    step();
    rst = 0; en = 1; mode = 2'b00; up_dn = 1; max_val = 5; prescale = 0;
    repeat (3) step();
    vec++;
    if (count !== 8'd3) begin
      errs++;
      $display("FAIL pre_reset_count got %0d required 3", count);
    end
    rst = 1;
    #1;
    vec++;
    if ({count, tc, busy, done} !== 11'd0) begin
      errs++;
      $display("FAIL reset_async count=%0d tc=%0b busy=%0b done=%0b required 0/0/0/0", count, tc, busy, done);
    end
    step();
    rst = 0;
  endtask
  task automatic test_wrap();
    int e[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    for (int i = 0; i < 8; i++) begin
      step();
      vec++;
      if (count !== e[i][7:0] || tc !== (e[i] == 5)) begin
        errs++;
        $display("FAIL wrap_%0d count=%0d tc=%0b required %0d/%0b", i, count, tc, e[i], e[i] == 5);
      end
    end
  endtask
  task automatic test_sat();
    int e[12] = '{3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
    mode = 2'b01; up_dn = 0; prescale = 2; load = 1; load_val = 3;
    step();
    load = 0;
    vec++;
    if (count !== 8'd3 || tc !== 1'b0) begin
      errs++;
      $display("FAIL sat_load count=%0d tc=%0b required 3/0", count, tc);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      vec++;
      if (count !== e[i][7:0] || tc !== (i == 8)) begin
        errs++;
        $display("FAIL sat_%0d count=%0d tc=%0b required %0d/%0b", i, count, tc, e[i], i == 8);
      end
    end
  endtask
  task automatic test_oneshot();
    logic st[7] = '{1, 1, 0, 0, 0, 1, 0};
    int cn[7] = '{0, 1, 2, 3, 3, 0, 1};
    logic bz[7] = '{1, 1, 1, 0, 0, 1, 1};
    logic dn[7] = '{0, 0, 0, 1, 1, 0, 0};
    logic t[7] = '{0, 0, 0, 1, 0, 0, 0};
    mode = 2'b10; up_dn = 1; max_val = 3; prescale = 0;
    for (int i = 0; i < 7; i++) begin
      start = st[i];
      step();
      vec++;
      if (count !== cn[i][7:0] || busy !== bz[i] || done !== dn[i] || tc !== t[i]) begin
        errs++;
        $display("FAIL oneshot_%0d count=%0d busy=%0b done=%0b tc=%0b required %0d/%0b/%0b/%0b",
                 i, count, busy, done, tc, cn[i], bz[i], dn[i], t[i]);
      end
    end
    start = 0;
  endtask
  task automatic test_load_tick();
    int e[3] = '{9, 9, 10};
    mode = 2'b00; up_dn = 1; prescale = 0; max_val = 9; load = 1; load_val = 8;
    step();
    load_val = 9;
    step();
    load = 0;
    vec++;
    if (count !== 8'd9 || tc !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL load_over_tick count=%0d tc=%0b busy=%0b required 9/0/0", count, tc, busy);
    end
    step();
    vec++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      errs++;
      $display("FAIL wrap_after_load count=%0d tc=%0b required 0/0", count, tc);
    end
    max_val = 20; prescale = 2; load = 1; load_val = 5;
    step();
    load = 0;
    step();
    load = 1; load_val = 9;
    step();
    load = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if (count !== e[i][7:0]) begin
        errs++;
        $display("FAIL load_div_clr_%0d count=%0d required %0d", i, count, e[i]);
      end
    end
  endtask
  task automatic test_enable();
    mode = 2'b10; up_dn = 1; max_val = 7; prescale = 1; start = 1;
    step();
    start = 0;
    repeat (3) step();
    vec++;
    if (count !== 8'd1 || busy !== 1'b1) begin
      errs++;
      $display("FAIL en_prerun count=%0d busy=%0b required 1/1", count, busy);
    end
    en = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      vec++;
      if (count !== 8'd1 || busy !== 1'b1 || done !== 1'b0) begin
        errs++;
        $display("FAIL en_freeze_%0d count=%0d busy=%0b done=%0b required 1/1/0", i, count, busy, done);
      end
    end
    en = 1;
    step();
    vec++;
    if (count !== 8'd2) begin
      errs++;
      $display("FAIL en_resume count=%0d required 2", count);
    end
    mode = 2'b11;
    repeat (2) step();
    vec++;
    if (count !== 8'd2 || busy !== 1'b0 || tc !== 1'b0) begin
      errs++;
      $display("FAIL hold_mode count=%0d busy=%0b tc=%0b required 2/0/0", count, busy, tc);
    end
    mode = 2'b00; prescale = 0; max_val = 20; load = 1; load_val = 7;
    step();
    load = 0; max_val = 2;
    step();
    vec++;
    if (count !== 8'd0 || tc !== 1'b0) begin
      errs++;
      $display("FAIL max_below_count count=%0d tc=%0b required 0/0", count, tc);
    end
  endtask
  initial begin
    test_reset();
    test_wrap();
    test_sat();
    test_oneshot();
    test_load_tick();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
